// File: rtl/l_driver_pkg.sv
// l_driver_pkg
//   Shared definitions for the left-side line driver and its bus neighbours
//   (rDriver, lMod): frame state encoding, fixed start/stop line levels and
//   the even-parity helper.
package l_driver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } l_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Callers zero-extend narrower payloads; the extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/l_driver_bit_timer.sv
// l_driver_bit_timer
//   Per-bit clock counter for l_driver. Counts 0..CLKS_PER_BIT-1 while run is
//   high and wraps at the end of every line bit; held at 0 while idle.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   run            a frame is in progress
//   restart        force the counter back to 0 (accept / abort)
//   pre_mid_tick   counter == CLKS_PER_BIT/2 - 1
//   mid_tick       counter == CLKS_PER_BIT/2
//   pre_end_tick   counter == CLKS_PER_BIT - 2
//   end_tick       counter == CLKS_PER_BIT - 1
module l_driver_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic pre_mid_tick,
  output logic mid_tick,
  output logic pre_end_tick,
  output logic end_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] PRE_MID = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] MID     = CNT_W'(CLKS_PER_BIT/2);
  localparam logic [CNT_W-1:0] PRE_END = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || restart || end_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pre_mid_tick = (cnt == PRE_MID);
  assign mid_tick     = (cnt == MID);
  assign pre_end_tick = (cnt == PRE_END);
  assign end_tick     = (cnt == LAST);

endmodule

// File: rtl/l_driver.sv
// l_driver
//   Left-side single-bit line driver. Accepts a DATA_W-bit word over a
//   valid/ready handshake and sends it as START, DATA (LSB first),
//   optional even PARITY, STOP, each bit CLKS_PER_BIT clocks long. Its own
//   line value is compared with the sensed line once per bit and the frame is
//   aborted on a mismatch.
//   Optional feature macro: L_DRIVER_PARITY_EN adds the PARITY bit.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   tx_data    payload, captured on accept
//   tx_valid   producer has a word
//   tx_ready   driver idle and able to accept
//   line_o     driven line value (registered)
//   line_oe    line output enable (registered)
//   line_i     sensed line value
//   busy       frame in progress
//   done       one-cycle pulse in the last cycle of a good frame
//   collision  one-cycle pulse in the midpoint cycle of the aborted bit
module l_driver
  import l_driver_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              line_o,
  output logic              line_oe,
  input  logic              line_i,
  output logic              busy,
  output logic              done,
  output logic              collision
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  l_state_e          state;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shreg;
  logic              accept;
  logic              abort;
  logic              mismatch;
  logic              shift_en;
  logic              pre_mid_tick;
  logic              mid_tick;
  logic              pre_end_tick;
  logic              end_tick;
`ifdef L_DRIVER_PARITY_EN
  logic              parity_q;
`endif

  assign accept = tx_valid && tx_ready;
  // The mismatch is registered into collision one cycle before the midpoint
  // so the pulse is visible in the midpoint cycle itself; the abort then
  // takes effect on the edge that ends that cycle.
  assign mismatch = busy && pre_mid_tick && (line_i != line_o);
  assign abort    = busy && mid_tick && collision;
  // shreg holds the bits not yet on the line; bit 0 is the next one to drive.
  assign shift_en = busy && end_tick && !abort && ((state == START) || (state == DATA));

  l_driver_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (busy),
    .restart     (accept || abort),
    .pre_mid_tick(pre_mid_tick),
    .mid_tick    (mid_tick),
    .pre_end_tick(pre_end_tick),
    .end_tick    (end_tick)
  );

  // Payload path (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= tx_data;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
`ifdef L_DRIVER_PARITY_EN
    if (accept) begin
      parity_q <= even_parity(32'(tx_data));
    end
`endif
  end

  // Frame control and registered line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      tx_ready  <= 1'b1;
      line_o    <= STOP_BIT;
      line_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
    end else begin
      done      <= 1'b0;
      collision <= mismatch;
      if (accept) begin
        state    <= START;
        bit_idx  <= '0;
        tx_ready <= 1'b0;
        busy     <= 1'b1;
        line_o   <= START_BIT;
        line_oe  <= 1'b1;
      end else if (busy) begin
        // done leads the STOP end by one edge so it lands in STOP's last cycle.
        if ((state == STOP) && pre_end_tick && !abort && !mismatch) begin
          done <= 1'b1;
        end
        if (abort) begin
          state    <= IDLE;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          line_o   <= STOP_BIT;
          line_oe  <= 1'b0;
        end else if (end_tick) begin
          case (state)
            START: begin
              state  <= DATA;
              line_o <= shreg[0];
            end
            DATA: begin
              if (bit_idx == LAST_IDX) begin
`ifdef L_DRIVER_PARITY_EN
                state  <= PARITY;
                line_o <= parity_q;
`else
                state  <= STOP;
                line_o <= STOP_BIT;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
                line_o  <= shreg[0];
              end
            end
`ifdef L_DRIVER_PARITY_EN
            PARITY: begin
              state  <= STOP;
              line_o <= STOP_BIT;
            end
`endif
            STOP: begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              line_o   <= STOP_BIT;
              line_oe  <= 1'b0;
            end
            default: begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              line_o   <= STOP_BIT;
              line_oe  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_l_driver.sv
// tb_l_driver
//   Directed bench for l_driver with DATA_W=8, CLKS_PER_BIT=4. Expected line
//   bit sequences are written out by hand per word, with and without the
//   parity bit (L_DRIVER_PARITY_EN).
module tb_l_driver;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef L_DRIVER_PARITY_EN
  localparam int NBITS = DATA_W + 3;
`else
  localparam int NBITS = DATA_W + 2;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              line_o;
  logic              line_oe;
  logic              line_i;
  logic              busy;
  logic              done;
  logic              collision;
  logic              force_hi;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Loopback unless the bench forces a foreign '1' onto the line.
  assign line_i = force_hi ? 1'b1 : line_o;

  l_driver #(
    .DATA_W      (DATA_W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .line_o   (line_o),
    .line_oe  (line_oe),
    .line_i   (line_i),
    .busy     (busy),
    .done     (done),
    .collision(collision)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  // Line order: start, d0..d7, [parity], stop.
  function automatic string frame_of(input logic [7:0] d);
    string s;
    case (d)
`ifdef L_DRIVER_PARITY_EN
      8'hA5:   s = "01010010101";
      8'h01:   s = "01000000011";
      8'h3C:   s = "00011110001";
      8'hC3:   s = "01100001101";
      8'h5A:   s = "00101101001";
`else
      8'hA5:   s = "0101001011";
      8'h01:   s = "0100000001";
      8'h3C:   s = "0001111001";
      8'hC3:   s = "0110000111";
      8'h5A:   s = "0010110101";
`endif
      default: s = "";
    endcase
    return s;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first START cycle.
  task automatic start_frame(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    chk("accept_ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Checks every cycle of a frame starting at the first START cycle, then the
  // idle cycle after it. Optionally pulses tx_valid with 0xFF mid-frame.
  task automatic run_frame(input logic [7:0] d, input bit inject);
    string s;
    s = frame_of(d);
    for (int b = 0; b < NBITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (inject && b == 4 && c == 1) begin
          tx_data  = 8'hFF;
          tx_valid = 1'b1;
        end
        if (inject && b == 4 && c == 2) tx_valid = 1'b0;
        chk($sformatf("line_oe %02h b%0d c%0d", d, b, c), line_oe, 1'b1);
        chk($sformatf("line_o %02h b%0d c%0d", d, b, c), line_o, s.getc(b) == "1");
        chk($sformatf("tx_ready %02h b%0d c%0d", d, b, c), tx_ready, 1'b0);
        chk($sformatf("busy %02h b%0d c%0d", d, b, c), busy, 1'b1);
        chk($sformatf("done %02h b%0d c%0d", d, b, c), done, (b == NBITS - 1) && (c == CPB - 1));
        chk($sformatf("collision %02h b%0d c%0d", d, b, c), collision, 1'b0);
        @(negedge clk);
      end
    end
    chk($sformatf("idle_oe %02h", d), line_oe, 1'b0);
    chk($sformatf("idle_line %02h", d), line_o, 1'b1);
    chk($sformatf("idle_ready %02h", d), tx_ready, 1'b1);
    chk($sformatf("idle_busy %02h", d), busy, 1'b0);
    chk($sformatf("idle_done %02h", d), done, 1'b0);
  endtask

  initial begin
    logic done_seen;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    force_hi = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst tx_ready", tx_ready, 1'b1);
    chk("rst line_o", line_o, 1'b1);
    chk("rst line_oe", line_oe, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst collision", collision, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single frames
    start_frame(8'hA5);
    run_frame(8'hA5, 1'b0);
    start_frame(8'h01);
    run_frame(8'h01, 1'b0);

    // Back-to-back with tx_valid held: 0xC3 presented during the 0x3C frame
    // must wait for the idle cycle after done.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    chk("b2b accept_ready", tx_ready, 1'b1);
    @(negedge clk);
    tx_data = 8'hC3;
    run_frame(8'h3C, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    run_frame(8'hC3, 1'b0);

    // Busy ignore: 0xFF pulsed mid-frame leaves the 0x5A stream intact
    start_frame(8'h5A);
    run_frame(8'h5A, 1'b1);
    repeat (3) begin
      chk("ignore stays idle", busy, 1'b0);
      @(negedge clk);
    end

    // Collision during START
    force_hi = 1'b1;
    start_frame(8'hA5);
    chk("coll c1 collision", collision, 1'b0);
    chk("coll c1 line_oe", line_oe, 1'b1);
    @(negedge clk);
    chk("coll c2 collision", collision, 1'b0);
    @(negedge clk);
    chk("coll c3 collision", collision, 1'b1);
    chk("coll c3 line_oe", line_oe, 1'b1);
    chk("coll c3 done", done, 1'b0);
    @(negedge clk);
    chk("coll c4 collision", collision, 1'b0);
    chk("coll c4 line_oe", line_oe, 1'b0);
    chk("coll c4 tx_ready", tx_ready, 1'b1);
    chk("coll c4 busy", busy, 1'b0);
    force_hi  = 1'b0;
    done_seen = 1'b0;
    repeat (8) begin
      done_seen = done_seen | done;
      @(negedge clk);
    end
    chk("coll no done", done_seen, 1'b0);

    // Reset in DATA bit 3
    start_frame(8'hA5);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    chk("pre-rst line_oe", line_oe, 1'b1);
    chk("pre-rst busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("async rst line_oe", line_oe, 1'b0);
    chk("async rst line_o", line_o, 1'b1);
    chk("async rst tx_ready", tx_ready, 1'b1);
    chk("async rst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_frame(8'h3C);
    run_frame(8'h3C, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
